// File: rtl/carrega_matrizes_if.sv
// -----------------------------------------------------------------------------
// carrega_matrizes_if
// Read-only byte bus between the matrix loader and the coprocessor data memory.
//   mem_addr : byte address presented by the loader
//   mem_rd   : read strobe, one read per cycle while high
//   mem_dado : read data, returned exactly one cycle after the matching mem_rd
// Handshake: there is no ready/stall; every cycle with mem_rd=1 is a read whose
// data the memory must place on mem_dado in the following cycle.
// Modports: master = loader side, slave = memory side.
// -----------------------------------------------------------------------------
interface carrega_matrizes_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_dado;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_dado
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_dado
  );
endinterface

// File: rtl/carrega_matrizes.sv
// -----------------------------------------------------------------------------
// carrega_matrizes
// Loads two 5x5 signed 8-bit matrices (A then B) byte by byte from data memory
// and presents them to the ULA as 200-bit buses, element k at [8k+7:8k].
// Reads land in shadow registers; matrizA/matrizB only change on commit, so the
// ULA never sees a half-loaded operand pair.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : load request, honoured only while idle
//   end_a, end_b      : base addresses of A and B, latched with start
//   memBus (master)   : memory read bus (mem_addr, mem_rd, mem_dado)
//   matrizA, matrizB  : committed matrices
//   ocupado           : load in progress
//   pronto            : one-cycle pulse, new matrices committed
//   estadoDbg         : current FSM state (IDLE=0, LEITURA=1, DRENA=2)
// -----------------------------------------------------------------------------
module carrega_matrizes #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   end_a,
  input  logic [ADDR_W-1:0]   end_b,
  carrega_matrizes_if.master  memBus,
  output logic [199:0]        matrizA,
  output logic [199:0]        matrizB,
  output logic                ocupado,
  output logic                pronto,
  output logic [1:0]          estadoDbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LEITURA = 2'd1;
  localparam logic [1:0] DRENA   = 2'd2;

  localparam logic [5:0] ULTIMO = 6'd49;  // last read index (B element 24)

  logic [1:0]        estado;
  logic [5:0]        cnt;       // index of the read currently on the bus
  logic [5:0]        cntQ;      // index of the read whose data is on mem_dado
  logic              rdQ;       // mem_dado carries valid data this cycle
  logic [ADDR_W-1:0] baseA;
  logic [ADDR_W-1:0] baseB;
  logic [199:0]      shadowA;
  logic [199:0]      shadowB;
  logic [199:0]      shadowANext;
  logic [199:0]      shadowBNext;
  logic [4:0]        slot;

  // Read index 0..24 addresses A, 25..49 addresses B; additions wrap modulo
  // 2^ADDR_W by truncation.
  function automatic logic [ADDR_W-1:0] enderecoDe(
    input logic [5:0]        idx,
    input logic [ADDR_W-1:0] bA,
    input logic [ADDR_W-1:0] bB
  );
    if (idx < 6'd25) enderecoDe = bA + ADDR_W'(idx);
    else             enderecoDe = bB + ADDR_W'(idx - 6'd25);
  endfunction

  // Shadow contents including this cycle's returning byte. The commit in DRENA
  // uses these so the final byte (index 49) is part of the committed pair.
  always_comb begin
    shadowANext = shadowA;
    shadowBNext = shadowB;
    slot        = '0;
    if (rdQ) begin
      if (cntQ < 6'd25) begin
        slot = cntQ[4:0];
        shadowANext[{slot, 3'b000} +: 8] = memBus.mem_dado;
      end else begin
        slot = 5'(cntQ - 6'd25);
        shadowBNext[{slot, 3'b000} +: 8] = memBus.mem_dado;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= IDLE;
      cnt             <= '0;
      cntQ            <= '0;
      rdQ             <= 1'b0;
      baseA           <= '0;
      baseB           <= '0;
      shadowA         <= '0;
      shadowB         <= '0;
      matrizA         <= '0;
      matrizB         <= '0;
      memBus.mem_addr <= '0;
      memBus.mem_rd   <= 1'b0;
      pronto          <= 1'b0;
    end else begin
      rdQ     <= memBus.mem_rd;
      cntQ    <= cnt;
      shadowA <= shadowANext;
      shadowB <= shadowBNext;
      pronto  <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            baseA           <= end_a;
            baseB           <= end_b;
            cnt             <= '0;
            memBus.mem_addr <= end_a;
            memBus.mem_rd   <= 1'b1;
            estado          <= LEITURA;
          end
        end
        LEITURA: begin
          if (cnt == ULTIMO) begin
            memBus.mem_rd <= 1'b0;  // address holds its last value
            estado        <= DRENA;
          end else begin
            cnt             <= cnt + 6'd1;
            memBus.mem_addr <= enderecoDe(cnt + 6'd1, baseA, baseB);
            memBus.mem_rd   <= 1'b1;
          end
        end
        DRENA: begin
          matrizA <= shadowANext;
          matrizB <= shadowBNext;
          pronto  <= 1'b1;
          estado  <= IDLE;
        end
        default: begin
          memBus.mem_rd <= 1'b0;
          estado        <= IDLE;
        end
      endcase
    end
  end

  assign ocupado   = (estado != IDLE);
  assign estadoDbg = estado;

endmodule

// File: tb/tb_carrega_matrizes.sv
// -----------------------------------------------------------------------------
// tb_carrega_matrizes
// Memory model answers reads one cycle later. A monitor pops expected addresses
// and expected committed matrices (with their pronto cycle) from queues filled
// when each start is driven; scenario tasks add their own timing checks.
// -----------------------------------------------------------------------------
module tb_carrega_matrizes;
  localparam int ADDR_W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   end_a = '0;
  logic [7:0]   end_b = '0;
  logic [199:0] matrizA, matrizB;
  logic         ocupado, pronto;
  logic [1:0]   estadoDbg;

  carrega_matrizes_if #(.ADDR_W(ADDR_W)) memBus();

  carrega_matrizes #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .end_a     (end_a),
    .end_b     (end_b),
    .memBus    (memBus),
    .matrizA   (matrizA),
    .matrizB   (matrizB),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .estadoDbg (estadoDbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  always @(posedge clk)
    if (memBus.mem_rd) memBus.mem_dado <= mem[memBus.mem_addr];

  // ---------------- scoreboard ----------------
  logic [7:0]   exp_q[$];       // expected read addresses in order
  logic [399:0] expMatQ[$];     // {A, B} expected at each pronto
  int           expCycQ[$];     // monitor cycle at which pronto is expected
  int           vecCount = 0;
  int           errCount = 0;
  int           cyc = 0;
  logic         rstAtEdge;
  logic [7:0]   expAddr;
  logic [399:0] expMat;
  int           expCyc;
  logic [199:0] holdA = '0;
  logic [199:0] holdB = '0;

  // Queue one load's expectations from the current memory contents.
  task automatic pushLoad(input logic [7:0] ea, input logic [7:0] eb, input int pCyc,
                          output logic [199:0] expA, output logic [199:0] expB);
    for (int k = 0; k < 25; k++) exp_q.push_back(8'(ea + k));
    for (int k = 0; k < 25; k++) exp_q.push_back(8'(eb + k));
    for (int k = 0; k < 25; k++) begin
      expA[8*k +: 8] = mem[8'(ea + k)];
      expB[8*k +: 8] = mem[8'(eb + k)];
    end
    expMatQ.push_back({expA, expB});
    expCycQ.push_back(pCyc);
  endtask

  // Monitor samples 2 time units after each rising edge.
  always @(posedge clk) begin
    rstAtEdge = reset;
    #2;
    cyc++;
    if (rstAtEdge) begin
      exp_q.delete();
      expMatQ.delete();
      expCycQ.delete();
      holdA = '0;
      holdB = '0;
    end
    if (memBus.mem_rd === 1'b1) begin
      vecCount++;
      if (exp_q.size() == 0) begin
        errCount++;
        $display("FAIL unexpected_read cyc=%0d addr=%h", cyc, memBus.mem_addr);
      end else begin
        expAddr = exp_q.pop_front();
        if (memBus.mem_addr !== expAddr) begin
          errCount++;
          $display("FAIL read_addr cyc=%0d got=%h exp=%h", cyc, memBus.mem_addr, expAddr);
        end
      end
    end
    if (pronto === 1'b1) begin
      vecCount++;
      if (expMatQ.size() == 0) begin
        errCount++;
        $display("FAIL unexpected_pronto cyc=%0d", cyc);
      end else begin
        expMat = expMatQ.pop_front();
        expCyc = expCycQ.pop_front();
        if (matrizA !== expMat[399:200]) begin
          errCount++;
          $display("FAIL commit_matrizA got=%h exp=%h", matrizA, expMat[399:200]);
        end
        if (matrizB !== expMat[199:0]) begin
          errCount++;
          $display("FAIL commit_matrizB got=%h exp=%h", matrizB, expMat[199:0]);
        end
        if (cyc !== expCyc) begin
          errCount++;
          $display("FAIL pronto_cycle got=%0d exp=%0d", cyc, expCyc);
        end
      end
      holdA = matrizA;
      holdB = matrizB;
    end else begin
      vecCount++;
      if (matrizA !== holdA || matrizB !== holdB) begin
        errCount++;
        $display("FAIL matrix_stable cyc=%0d A=%h B=%h", cyc, matrizA, matrizB);
        holdA = matrizA;
        holdB = matrizB;
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecCount++; if (memBus.mem_rd !== 1'b0) begin errCount++; $display("FAIL rst_mem_rd got=%b exp=0", memBus.mem_rd); end
    vecCount++; if (memBus.mem_addr !== 8'h00) begin errCount++; $display("FAIL rst_mem_addr got=%h exp=00", memBus.mem_addr); end
    vecCount++; if (ocupado !== 1'b0) begin errCount++; $display("FAIL rst_ocupado got=%b exp=0", ocupado); end
    vecCount++; if (pronto !== 1'b0) begin errCount++; $display("FAIL rst_pronto got=%b exp=0", pronto); end
    vecCount++; if (matrizA !== '0 || matrizB !== '0) begin errCount++; $display("FAIL rst_matrices A=%h B=%h exp=0", matrizA, matrizB); end
    vecCount++; if (estadoDbg !== 2'd0) begin errCount++; $display("FAIL rst_state got=%0d exp=0", estadoDbg); end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      vecCount++;
      if (memBus.mem_rd !== 1'b0) begin errCount++; $display("FAIL idle_mem_rd cycle=%0d got=%b exp=0", i, memBus.mem_rd); end
    end
  endtask

  task automatic test_basic();
    logic [199:0] eA, eB;
    for (int k = 0; k < 25; k++) begin
      mem[8'(8'h10 + k)] = 8'(k + 1);
      mem[8'(8'h40 + k)] = 8'(8'h80 + k);
    end
    end_a = 8'h10; end_b = 8'h40;
    pushLoad(8'h10, 8'h40, cyc + 53, eA, eB);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;   // cycle 1
    vecCount++; if (ocupado !== 1'b1 || memBus.mem_rd !== 1'b1) begin errCount++; $display("FAIL basic_c1 ocupado=%b mem_rd=%b exp=1,1", ocupado, memBus.mem_rd); end
    vecCount++; if (estadoDbg !== 2'd1) begin errCount++; $display("FAIL basic_c1_state got=%0d exp=1", estadoDbg); end
    repeat (50) @(posedge clk);
    #1;                                  // cycle 51
    vecCount++; if (ocupado !== 1'b1 || memBus.mem_rd !== 1'b0 || pronto !== 1'b0) begin errCount++; $display("FAIL basic_c51 ocupado=%b mem_rd=%b pronto=%b exp=1,0,0", ocupado, memBus.mem_rd, pronto); end
    vecCount++; if (estadoDbg !== 2'd2) begin errCount++; $display("FAIL basic_c51_state got=%0d exp=2", estadoDbg); end
    @(posedge clk); #1;                  // cycle 52
    vecCount++; if (pronto !== 1'b1 || ocupado !== 1'b0) begin errCount++; $display("FAIL basic_c52 pronto=%b ocupado=%b exp=1,0", pronto, ocupado); end
    vecCount++; if (matrizA[7:0] !== 8'h01 || matrizA[199:192] !== 8'h19) begin errCount++; $display("FAIL basic_A_ends got=%h,%h exp=01,19", matrizA[7:0], matrizA[199:192]); end
    vecCount++; if (matrizB[7:0] !== 8'h80 || matrizB[199:192] !== 8'h98) begin errCount++; $display("FAIL basic_B_ends got=%h,%h exp=80,98", matrizB[7:0], matrizB[199:192]); end
    @(posedge clk); #1;
    vecCount++; if (pronto !== 1'b0) begin errCount++; $display("FAIL basic_pronto_pulse got=%b exp=0", pronto); end
  endtask

  task automatic test_wrap();
    logic [199:0] eA, eB;
    logic found;
    for (int k = 0; k < 25; k++) begin
      mem[8'(8'hF0 + k)] = 8'($urandom_range(0, 255));
      mem[8'(8'h20 + k)] = 8'($urandom_range(0, 255));
    end
    end_a = 8'hF0; end_b = 8'h20;
    pushLoad(8'hF0, 8'h20, cyc + 53, eA, eB);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (pronto === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vecCount++; if (!found) begin errCount++; $display("FAIL wrap_pronto_timeout got=0 exp=1"); end
    vecCount++; if (matrizA[135:128] !== mem[8'h00]) begin errCount++; $display("FAIL wrap_elem16 got=%h exp=%h", matrizA[135:128], mem[8'h00]); end
  endtask

  task automatic test_busy();
    logic [199:0] eA, eB;
    end_a = 8'h10; end_b = 8'h40;
    pushLoad(8'h10, 8'h40, cyc + 53, eA, eB);
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(posedge clk); #1;
      start = (c == 10 || c == 30);
      if (c == 10) begin
        vecCount++; if (ocupado !== 1'b1) begin errCount++; $display("FAIL busy_ocupado got=%b exp=1", ocupado); end
      end
      if (c == 52) begin
        vecCount++; if (pronto !== 1'b1) begin errCount++; $display("FAIL busy_pronto got=%b exp=1", pronto); end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vecCount++; if (memBus.mem_rd !== 1'b0 || ocupado !== 1'b0) begin errCount++; $display("FAIL busy_not_queued mem_rd=%b ocupado=%b exp=0,0", memBus.mem_rd, ocupado); end
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] a1, b1, a2, b2;
    for (int k = 0; k < 25; k++) begin
      mem[8'(8'h60 + k)] = 8'($urandom_range(0, 255));
      mem[8'(8'h90 + k)] = 8'($urandom_range(0, 255));
    end
    end_a = 8'h10; end_b = 8'h40;
    pushLoad(8'h10, 8'h40, cyc + 53, a1, b1);
    pushLoad(8'h60, 8'h90, cyc + 105, a2, b2);
    start = 1'b1;
    for (int c = 1; c <= 104; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin end_a = 8'h60; end_b = 8'h90; end
      if (c == 60) start = 1'b0;
      if (c == 52) begin
        vecCount++; if (pronto !== 1'b1) begin errCount++; $display("FAIL b2b_pronto1 got=%b exp=1", pronto); end
      end
      if (c == 53) begin
        vecCount++; if (memBus.mem_rd !== 1'b1 || memBus.mem_addr !== 8'h60) begin errCount++; $display("FAIL b2b_first_read2 rd=%b addr=%h exp=1,60", memBus.mem_rd, memBus.mem_addr); end
      end
      if (c == 103) begin
        vecCount++; if (matrizA !== a1 || matrizB !== b1) begin errCount++; $display("FAIL b2b_hold_load1 A=%h exp=%h", matrizA, a1); end
      end
      if (c == 104) begin
        vecCount++; if (pronto !== 1'b1 || matrizA !== a2 || matrizB !== b2) begin errCount++; $display("FAIL b2b_load2 pronto=%b A=%h exp=%h", pronto, matrizA, a2); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [199:0] eA, eB;
    logic found;
    for (int k = 0; k < 25; k++) begin
      mem[8'(8'h10 + k)] = 8'(8'hC0 + k);
      mem[8'(8'h40 + k)] = 8'(8'h33 ^ k);
    end
    end_a = 8'h10; end_b = 8'h40;
    pushLoad(8'h10, 8'h40, cyc + 53, eA, eB);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 30) reset = 1'b1;
    end
    @(posedge clk); #1;                  // cycle 31, first cycle after reset
    vecCount++; if (matrizA !== '0 || matrizB !== '0) begin errCount++; $display("FAIL midrst_matrices A=%h B=%h exp=0", matrizA, matrizB); end
    vecCount++; if (memBus.mem_rd !== 1'b0 || memBus.mem_addr !== 8'h00 || ocupado !== 1'b0 || pronto !== 1'b0) begin errCount++; $display("FAIL midrst_outputs rd=%b addr=%h ocupado=%b pronto=%b exp=0,00,0,0", memBus.mem_rd, memBus.mem_addr, ocupado, pronto); end
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      vecCount++; if (pronto !== 1'b0 || matrizA !== '0) begin errCount++; $display("FAIL midrst_no_commit pronto=%b A=%h exp=0,0", pronto, matrizA); end
    end
    // Reset for one cycle, then start in the very first cycle with reset low.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1;          // cycle 0 of clean load
    @(posedge clk); #1; start = 1'b0;    // cycle 1
    pushLoad(8'h10, 8'h40, cyc + 52, eA, eB);
    vecCount++; if (memBus.mem_rd !== 1'b1 || memBus.mem_addr !== 8'h10) begin errCount++; $display("FAIL midrst_start_after_reset rd=%b addr=%h exp=1,10", memBus.mem_rd, memBus.mem_addr); end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (pronto === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vecCount++; if (!found) begin errCount++; $display("FAIL midrst_clean_timeout got=0 exp=1"); end
    vecCount++; if (matrizA !== eA || matrizB !== eB) begin errCount++; $display("FAIL midrst_clean_values A=%h exp=%h", matrizA, eA); end
  endtask

  task automatic test_signed();
    logic [199:0] eA, eB;
    logic found;
    for (int k = 0; k < 25; k++) begin
      mem[8'(8'h70 + k)] = 8'(k);
      mem[8'(8'hA0 + k)] = 8'($urandom_range(0, 255));
    end
    mem[8'h70 + 8'd12] = 8'hFF;
    end_a = 8'h70; end_b = 8'hA0;
    pushLoad(8'h70, 8'hA0, cyc + 53, eA, eB);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (pronto === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vecCount++; if (!found) begin errCount++; $display("FAIL signed_timeout got=0 exp=1"); end
    vecCount++; if (matrizA[103:96] !== 8'hFF) begin errCount++; $display("FAIL signed_elem12 got=%h exp=ff", matrizA[103:96]); end
    vecCount++; if (matrizA[95:88] !== 8'd11 || matrizA[111:104] !== 8'd13) begin errCount++; $display("FAIL signed_neighbours got=%h,%h exp=0b,0d", matrizA[95:88], matrizA[111:104]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    repeat (5) @(posedge clk);
    #3;
    vecCount++;
    if (exp_q.size() != 0 || expMatQ.size() != 0) begin
      errCount++;
      $display("FAIL leftover_expectations reads=%0d commits=%0d exp=0,0", exp_q.size(), expMatQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/carrega_matrizes.md
# carrega_matrizes

Matrix operand loader for the coprocessor ULA. On a start pulse it reads two 5x5 signed 8-bit matrices, A then B, byte by byte from the coprocessor data memory. It packs them into the 200-bit `matrizA`/`matrizB` buses consumed by the ULA matrix operators. Results are double-buffered, so the ULA only ever sees a complete, stable operand pair.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: load request; sampled only in IDLE.
- `end_a`, in, ADDR_W: base address of matrix A; sampled with `start`.
- `end_b`, in, ADDR_W: base address of matrix B; sampled with `start`.
- `mem_addr`, out, ADDR_W: memory read address.
- `mem_rd`, out, 1: read strobe.
- `mem_dado`, in, 8: read data, valid exactly 1 cycle after the matching `mem_rd`.
- `matrizA`, out, 200: committed matrix A; element k at `[8k+7:8k]`.
- `matrizB`, out, 200: committed matrix B, same layout.
- `ocupado`, out, 1: load in progress.
- `pronto`, out, 1: one-cycle pulse; new matrices are committed.

## Operation
- Element layout: row-major, element (r,c) has index k = 5r+c, k = 0..24. Memory byte at `base+k` maps to element k. Bytes are stored unchanged, as two's complement.
- The FSM has 3 states: IDLE, LEITURA, DRENA.
- IDLE:
  - `start=1` latches `end_a`/`end_b` and clears the read counter `cnt` (0..49). Go to LEITURA.
  - Otherwise stay in IDLE.
- LEITURA:
  - `mem_rd=1` every cycle.
  - `cnt` 0..24 drives `mem_addr = end_a + cnt`; `cnt` 25..49 drives `mem_addr = end_b + (cnt-25)`.
  - Address addition is modulo 2^ADDR_W, so it wraps with no error.
  - After `cnt=49`, go to DRENA.
- Capture: a registered copy of the previous cycle's `mem_rd`/`cnt` tags `mem_dado`. The byte is written into shadow slot `cnt`:
  - slots 0..24 go to shadow A;
  - slots 25..49 go to shadow B, element `cnt-25`.
- DRENA:
  - `mem_rd=0`; the last byte (`cnt=49`) is captured.
  - At the end of the cycle, both shadows are copied to `matrizA`/`matrizB` simultaneously.
  - `pronto` is set for the next cycle. Return to IDLE.
- `matrizA`/`matrizB` change only on commit. Between commits they hold their value, including throughout a new load.
- `start` while `ocupado=1` is ignored and not queued.
- `mem_rd=0` outside LEITURA. `mem_addr` holds its last value when idle (don't-care to memory).
- Reset (any state, including mid-load):
  - state becomes IDLE and `cnt` becomes 0;
  - shadows are discarded, with no commit;
  - `matrizA`, `matrizB`, `mem_addr` are cleared to 0;
  - `mem_rd`, `ocupado`, `pronto` are cleared to 0.

## Timing
- Cycle 0: `start=1` sampled in IDLE.
- Cycles 1..50: `mem_rd=1`, addresses in the order A0..A24, B0..B24.
- Cycles 2..51: `mem_dado` is captured.
- Cycle 51: DRENA.
- Cycle 52:
  - `pronto=1`;
  - new `matrizA`/`matrizB` are visible;
  - state is IDLE, so a `start` in cycle 52 is accepted (next load's first read in cycle 53).
- Start-to-`pronto` latency is 52 cycles. Back-to-back throughput is one load per 52 cycles.
- `ocupado=1` in cycles 1..51 and 0 in cycle 52.
- `pronto` is high for exactly one cycle per completed load and never after an aborted one.
- Reset asserted in cycle n:
  - all outputs are at reset values in cycle n+1;
  - `start` is honoured from the first cycle in which `reset=0`.

## Test plan
- Reset, then idle: all outputs 0; `mem_rd` stays 0 for 100 cycles with `start=0`.
- Basic load:
  - setup: memory[0x10+k] = k+1, memory[0x40+k] = 0x80+k; `start` with `end_a=0x10`, `end_b=0x40`;
  - addresses must be 0x10..0x28 then 0x40..0x58;
  - `pronto` in cycle 52;
  - `matrizA[7:0]=0x01`, `matrizA[199:192]=0x19`, `matrizB[7:0]=0x80`, `matrizB[199:192]=0x98`.
- Address wrap:
  - setup: `end_a=0xF0`, ADDR_W=8;
  - addresses must run 0xF0..0xFF, then 0x00..0x08;
  - A element 16 = memory[0x00].
- Busy and back-to-back:
  - `start` held high for 60 cycles gives loads starting in cycles 0 and 52;
  - `start` pulses in cycles 10 and 30 are ignored;
  - matrices from load 1 stay stable until cycle 104.
- Reset mid-load:
  - setup: load 1 committed (known values), then a second load with different memory contents;
  - assert `reset` in cycle 30 of load 2;
  - matrices go to 0, no `pronto`;
  - a subsequent clean load commits correct values.
- Signed data: a byte of 0xFF loaded into element 12 appears unchanged at `matrizA[103:96]=0xFF`. No sign extension or other element altered.
